// File: rtl/servo_cmd_slew.sv
// servo_cmd_slew -- position sequencer feeding the servo PWM driver.
//
// Accepts 8-bit target positions over a valid/ready handshake, holds one
// pending command, and once per update tick moves the driver's position byte
// toward the target by at most STEP counts. The driver's data/enable inputs
// are produced directly from registers.
//
// Optional feature macro: SERVO_IDLE_TIMEOUT_EN
//   When defined, enable drops after IDLE_FRAMES idle ticks in HOLD and is
//   raised again by the next accepted command. When undefined, enable stays
//   high from the first cycle after reset and no idle counter exists.
//
// Parameters:
//   TICK_CYCLES  clock cycles per update tick (>= 2)
//   STEP         maximum position change per tick (1..255, 255 = jump)
//   HOME_POS     position loaded at reset
//   IDLE_FRAMES  idle ticks before enable drops (timeout build only)
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   cmd_valid  command present
//   cmd_pos    target position
//   cmd_ready  block can accept a command (pending buffer empty, out of reset)
//   data       position to the servo driver (registered)
//   enable     enable to the servo driver (registered)
//   busy       data != target, or a command is pending
//   at_target  !busy
module servo_cmd_slew #(
  parameter int unsigned TICK_CYCLES = 1500002,
  parameter int unsigned STEP        = 4,
  parameter logic [7:0]  HOME_POS    = 8'd128,
  parameter int unsigned IDLE_FRAMES = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_pos,
  output logic       cmd_ready,
  output logic [7:0] data,
  output logic       enable,
  output logic       busy,
  output logic       at_target
);

  localparam int unsigned TW    = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [7:0] STEP8 = 8'(STEP);

  if (TICK_CYCLES < 2 || STEP < 1 || STEP > 255 || IDLE_FRAMES < 1) begin : g_bad_param
    $error("servo_cmd_slew: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_OFF,
    ST_HOLD,
    ST_RAMP
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [7:0]      target, target_n;
  logic [7:0]      pend_pos, pend_pos_n;
  logic            pend_full, pend_full_n;
  logic [7:0]      data_n;
  logic [7:0]      eff;
  logic [8:0]      diff;
  logic            accept;
  logic            enable_n;

  // ---------------------------------------------------------------------------
  // Update tick: free-running 0..TICK_CYCLES-1
  // ---------------------------------------------------------------------------
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake and status
  // ---------------------------------------------------------------------------
  assign cmd_ready = (state != ST_OFF) && !pend_full;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (data != target) || pend_full;
  assign at_target = !busy;

  // Pending value wins over the held target when present.
  assign eff = pend_full ? pend_pos : target;

  // ---------------------------------------------------------------------------
  // Position / target / pending buffer next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    data_n      = data;
    target_n    = target;
    pend_pos_n  = pend_pos;
    pend_full_n = pend_full;
    diff        = '0;

    if (tick) begin
      target_n    = eff;
      pend_full_n = 1'b0;
      if (eff > data) begin
        diff = {1'b0, eff} - {1'b0, data};
        // diff > STEP guarantees data + STEP stays below eff, so no wrap.
        data_n = (diff <= STEP9) ? eff : data + STEP8;
      end else if (eff < data) begin
        diff = {1'b0, data} - {1'b0, eff};
        data_n = (diff <= STEP9) ? eff : data - STEP8;
      end
    end

    // An accept only happens with the buffer empty, so a same-cycle tick has
    // already used the old target; the new command waits for the next tick.
    if (accept) begin
      pend_full_n = 1'b1;
      pend_pos_n  = cmd_pos;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: OFF -> HOLD, then HOLD/RAMP from the next-cycle values
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    case (state)
      ST_OFF:  state_n = ST_HOLD;
      default: state_n = ((data_n == target_n) && !pend_full_n) ? ST_HOLD : ST_RAMP;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Driver enable
  // ---------------------------------------------------------------------------
`ifdef SERVO_IDLE_TIMEOUT_EN
  localparam int unsigned IW = $clog2(IDLE_FRAMES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_FRAMES);

  logic [IW-1:0] idle_cnt, idle_n;

  always_comb begin
    idle_n   = idle_cnt;
    enable_n = enable;
    if (state == ST_OFF) begin
      enable_n = 1'b1;
    end
    if (accept) begin
      idle_n   = '0;
      enable_n = 1'b1;
    end else if (tick && (state == ST_HOLD) && (idle_cnt != IDLE_LAST)) begin
      idle_n = idle_cnt + 1'b1;
      if (idle_n == IDLE_LAST) begin
        enable_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_n;
    end
  end
`else
  always_comb begin
    enable_n = 1'b1;
  end
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_OFF;
      data      <= HOME_POS;
      target    <= HOME_POS;
      pend_pos  <= '0;
      pend_full <= 1'b0;
      enable    <= 1'b0;
    end else begin
      state     <= state_n;
      data      <= data_n;
      target    <= target_n;
      pend_pos  <= pend_pos_n;
      pend_full <= pend_full_n;
      enable    <= enable_n;
    end
  end

endmodule

// File: tb/tb_servo_cmd_slew.sv
// Scoreboard bench for servo_cmd_slew. Instance A uses STEP=4, instance B
// uses STEP=255 (immediate jump). Stimulus pushes expected data/busy values
// into per-instance queues; the monitor pops an entry every time a DUT's data
// output changes. Status checks are queued by the stimulus and compared by
// the monitor, which owns the check counters.
module tb_servo_cmd_slew;

  typedef struct packed {
    logic [7:0] d;
    logic       b;
  } exp_t;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } chk_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid_a, cmd_valid_b;
  logic [7:0] cmd_pos_a, cmd_pos_b;
  logic       cmd_ready_a, cmd_ready_b;
  logic [7:0] data_a, data_b;
  logic       enable_a, enable_b;
  logic       busy_a, busy_b;
  logic       at_a, at_b;

  exp_t qa[$];
  exp_t qb[$];
  chk_t sq[$];

  int errors = 0;
  int checks = 0;
  logic mon_on = 1'b0;
  logic have_prev = 1'b0;
  logic [7:0] prev_a, prev_b;

  always #5 clk = ~clk;

  servo_cmd_slew #(
    .TICK_CYCLES(10), .STEP(4), .HOME_POS(8'd128), .IDLE_FRAMES(3)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid_a), .cmd_pos(cmd_pos_a),
    .cmd_ready(cmd_ready_a), .data(data_a), .enable(enable_a),
    .busy(busy_a), .at_target(at_a)
  );

  servo_cmd_slew #(
    .TICK_CYCLES(10), .STEP(255), .HOME_POS(8'd128), .IDLE_FRAMES(3)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid_b), .cmd_pos(cmd_pos_b),
    .cmd_ready(cmd_ready_b), .data(data_b), .enable(enable_b),
    .busy(busy_b), .at_target(at_b)
  );

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: drains queued status checks, then scores data changes.
  always @(negedge clk) begin
    chk_t c;
    exp_t e;
    while (sq.size() > 0) begin
      c = sq.pop_front();
      cmp(c.name, c.act, c.exp);
    end
    if (mon_on) begin
      if (have_prev) begin
        if (data_a !== prev_a) begin
          if (qa.size() == 0) begin
            cmp("a_unexpected_change", int'(data_a), int'(prev_a));
          end else begin
            e = qa.pop_front();
            cmp("a_data", int'(data_a), int'(e.d));
            cmp("a_busy", int'(busy_a), int'(e.b));
            cmp("a_at_target", int'(at_a), int'(!e.b));
          end
        end
        if (data_b !== prev_b) begin
          if (qb.size() == 0) begin
            cmp("b_unexpected_change", int'(data_b), int'(prev_b));
          end else begin
            e = qb.pop_front();
            cmp("b_data", int'(data_b), int'(e.d));
            cmp("b_busy", int'(busy_b), int'(e.b));
          end
        end
      end
      prev_a    = data_a;
      prev_b    = data_b;
      have_prev = 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    sq.push_back(c);
  endtask

  task automatic push_a(input int d, input logic b);
    exp_t e;
    e.d = 8'(d);
    e.b = b;
    qa.push_back(e);
  endtask

  task automatic push_b(input int d, input logic b);
    exp_t e;
    e.d = 8'(d);
    e.b = b;
    qb.push_back(e);
  endtask

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send_a(input logic [7:0] p);
    int n = 0;
    cmd_valid_a = 1'b1;
    cmd_pos_a   = p;
    while (!cmd_ready_a && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("a_send_stall_bound", int'(n >= 200), 0);
    @(posedge clk); #1;
    cmd_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] p);
    int n = 0;
    cmd_valid_b = 1'b1;
    cmd_pos_b   = p;
    while (!cmd_ready_b && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b_send_stall_bound", int'(n >= 200), 0);
    @(posedge clk); #1;
    cmd_valid_b = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((qa.size() + qb.size()) > 0 && n < 800) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, qa.size() + qb.size(), 0);
  endtask

  initial begin
    int exp_idle_en;
    reset_n     = 1'b0;
    cmd_valid_a = 1'b0;
    cmd_valid_b = 1'b0;
    cmd_pos_a   = '0;
    cmd_pos_b   = '0;

    // Reset state
    repeat (5) @(posedge clk);
    #1;
    chk("rst_data", int'(data_a), 128);
    chk("rst_enable", int'(enable_a), 0);
    chk("rst_ready", int'(cmd_ready_a), 0);
    chk("rst_b_data", int'(data_b), 128);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_enable", int'(enable_a), 1);
    chk("post_rst_ready", int'(cmd_ready_a), 1);
    chk("post_rst_at_target", int'(at_a), 1);
    mon_on = 1'b1;

    // Ramp up 128 -> 138
    push_a(132, 1'b1);
    push_a(136, 1'b1);
    push_a(138, 1'b0);
    send_a(8'd138);
    chk("ramp_busy", int'(busy_a), 1);
    drain("ramp_drain");

    // Back-pressure: 100 then 200; 138 -> 134, then up to 200
    send_a(8'd100);
    chk("bp_ready_low", int'(cmd_ready_a), 0);
    push_a(134, 1'b1);
    for (int v = 138; v <= 198; v += 4) push_a(v, 1'b1);
    push_a(200, 1'b0);
    send_a(8'd200);
    drain("bp_drain");

    // Down to 2, then 0 in one tick (floor)
    for (int v = 196; v >= 4; v -= 4) push_a(v, 1'b1);
    push_a(2, 1'b0);
    send_a(8'd2);
    drain("down_drain");
    push_a(0, 1'b0);
    send_a(8'd0);
    drain("floor_drain");

    // STEP=255 instance: jump to 253, then 255 with no wrap
    push_b(253, 1'b0);
    send_b(8'd253);
    drain("b_jump_drain");
    push_b(255, 1'b0);
    send_b(8'd255);
    drain("b_ceiling_drain");

    // Asynchronous reset mid-ramp with a command pending
    push_a(4, 1'b1);
    push_a(8, 1'b1);
    send_a(8'd50);
    drain("pre_reset_drain");
    send_a(8'd60);
    chk("pre_reset_busy", int'(busy_a), 1);
    chk("pre_reset_ready", int'(cmd_ready_a), 0);
    @(posedge clk); #3;
    push_a(128, 1'b0);
    push_b(128, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_data", int'(data_a), 128);
    chk("mid_rst_enable", int'(enable_a), 0);
    chk("mid_rst_ready", int'(cmd_ready_a), 0);
    chk("mid_rst_busy", int'(busy_a), 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rerst_ready", int'(cmd_ready_a), 1);
    chk("rerst_at_target", int'(at_a), 1);
    chk("rerst_enable", int'(enable_a), 1);

    // Idle for more than three ticks; pending 60 must not reappear
    repeat (35) @(posedge clk);
    #1;
`ifdef SERVO_IDLE_TIMEOUT_EN
    exp_idle_en = 0;
`else
    exp_idle_en = 1;
`endif
    chk("idle_enable", int'(enable_a), exp_idle_en);
    chk("idle_data", int'(data_a), 128);
    send_a(8'd128);
    chk("wake_enable", int'(enable_a), 1);
    chk("wake_data", int'(data_a), 128);

    repeat (20) @(posedge clk);
    #1;
    chk("qa_left", qa.size(), 0);
    chk("qb_left", qb.size(), 0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
